fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the program counter, driving its `pc_write` enable. Issues one instruction-memory request per PC value over a valid/ready style handshake and captures the returned word into the IF/ID pipeline register for decode. Handles decode-stage stalls with a one-entry hold buffer, and handles branch/jump flushes by discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/if_id_register.sv | 39 +++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 tb/tb_fetch_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state type, default widths and the NOP encoding.
package fetch_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int INSTR_W_DEF = 32;

   // IF/ID contents after reset or flush
   localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: instruction, PC and precomputed PC+1 for decode.
// Clear has priority over load; with neither asserted the register holds.
module if_id_register
   import fetch_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [XLEN-1:0]    load_pc,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [XLEN-1:0]    id_pc,
   output logic [XLEN-1:0]    id_pc_plus_1
);

   // PC+1 is registered so it reads 0 out of reset and wraps modulo 2^XLEN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_valid     <= 1'b0;
         id_instr     <= INSTR_W'(NOP_INSTR);
         id_pc        <= '0;
         id_pc_plus_1 <= '0;
      end else if (clear) begin
         id_valid <= 1'b0;
         id_instr <= INSTR_W'(NOP_INSTR);
      end else if (load) begin
         id_valid     <= 1'b1;
         id_instr     <= load_instr;
         id_pc        <= load_pc;
         id_pc_plus_1 <= load_pc + XLEN'(1);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one request per PC, one-entry stall buffer, flush discard.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cycles counters.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [XLEN-1:0]    pc_in,
   output logic               pc_write,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               flush,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [XLEN-1:0]    id_pc,
   output logic [XLEN-1:0]    id_pc_plus_1
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall_cycles
`endif
);

   fetch_state_t       state;
   fetch_state_t       next_state;
   logic [INSTR_W-1:0] hold_instr;
   logic [XLEN-1:0]    hold_pc;
   logic [XLEN-1:0]    kill_addr;
   logic               pc_write_raw;
   logic               req_raw;
   logic               ifid_load;
   logic               ifid_clear;
   logic               buf_capture;
   logic [INSTR_W-1:0] load_instr;
   logic [XLEN-1:0]    load_pc;
   logic               decode_busy;

   assign decode_busy = stall & id_valid;

   // Handshake outputs stay quiet while reset is held
   assign pc_write = pc_write_raw & ~reset;
   assign imem_req = req_raw & ~reset;

   // Flush outranks everything; otherwise the response goes to IF/ID or the hold buffer
   always_comb begin
      next_state   = state;
      pc_write_raw = 1'b0;
      req_raw      = 1'b0;
      imem_addr    = pc_in;
      ifid_load    = 1'b0;
      ifid_clear   = 1'b0;
      buf_capture  = 1'b0;
      load_instr   = imem_rdata;
      load_pc      = pc_in;
      case (state)
         FETCH: begin
            req_raw = 1'b1;
            if (flush) begin
               pc_write_raw = 1'b1;
               ifid_clear   = 1'b1;
               next_state   = imem_ready ? FETCH : DISCARD;
            end else if (imem_ready) begin
               if (decode_busy) begin
                  buf_capture = 1'b1;
                  next_state  = HOLD;
               end else begin
                  ifid_load    = 1'b1;
                  pc_write_raw = 1'b1;
               end
            end else if (!decode_busy) begin
               ifid_clear = 1'b1;
            end
         end
         HOLD: begin
            load_instr = hold_instr;
            load_pc    = hold_pc;
            if (flush) begin
               pc_write_raw = 1'b1;
               ifid_clear   = 1'b1;
               next_state   = FETCH;
            end else if (!stall) begin
               ifid_load    = 1'b1;
               pc_write_raw = 1'b1;
               next_state   = FETCH;
            end
         end
         DISCARD: begin
            req_raw   = 1'b1;
            imem_addr = kill_addr;
            if (flush) begin
               pc_write_raw = 1'b1;
               ifid_clear   = 1'b1;
            end else if (imem_ready) begin
               next_state = FETCH;
            end
         end
         default: next_state = FETCH;
      endcase
   end

   // kill_addr tracks the live request address so DISCARD can keep it stable after redirect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= FETCH;
         hold_instr <= INSTR_W'(NOP_INSTR);
         hold_pc    <= '0;
         kill_addr  <= '0;
      end else begin
         state <= next_state;
         if (flush) begin
            hold_instr <= INSTR_W'(NOP_INSTR);
            hold_pc    <= '0;
         end else if (buf_capture) begin
            hold_instr <= imem_rdata;
            hold_pc    <= pc_in;
         end
         if (state == FETCH) begin
            kill_addr <= pc_in;
         end
      end
   end

   if_id_register #(
      .XLEN    (XLEN),
      .INSTR_W (INSTR_W)
   ) u_if_id (
      .clk          (clk),
      .reset        (reset),
      .load         (ifid_load),
      .clear        (ifid_clear),
      .load_instr   (load_instr),
      .load_pc      (load_pc),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .id_pc_plus_1 (id_pc_plus_1)
   );

`ifdef FETCH_PERF_CNT_EN
   // Free-running counters, wrapping at 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched      <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (ifid_load) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (decode_busy) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: the bench plays PC and instruction memory.
// Expected IF/ID loads are queued at response time and popped by a separate monitor.
module tb_fetch_stage;
   import fetch_pkg::*;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        pc_write;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        flush;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus_1;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall_cycles;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.XLEN(32), .INSTR_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_in        (pc_in),
      .pc_write     (pc_write),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .stall        (stall),
      .flush        (flush),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .id_pc_plus_1 (id_pc_plus_1)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched      (perf_fetched),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   exp_t        sb_q[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          lat_min    = 1;
   int          lat_max    = 1;
   int          stall_pct  = 0;
   int          flush_pct  = 0;

   // Reference model state: program counter, memory transaction, IF/ID occupancy
   logic [31:0] pc_model;
   logic [31:0] req_pc;
   bit          outstanding;
   bit          killed;
   bit          holding;
   bit          m_valid;
   int          lat_left;
   int          loads_model;
   int          loads_seen;
   int          stall_model;

   bit          mon_valid;
   logic [31:0] mon_pc;
   logic [31:0] mon_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA0000001;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      sb_q.delete();
      pc_model    = '0;
      req_pc      = '0;
      outstanding = 0;
      killed      = 0;
      holding     = 0;
      m_valid     = 0;
      lat_left    = 0;
      loads_model = 0;
      loads_seen  = 0;
      stall_model = 0;
   endtask

   task automatic checkReset();
      checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
      checkOutput("rst_id_instr", id_instr, 32'd0);
      checkOutput("rst_id_pc", id_pc, 32'd0);
      checkOutput("rst_id_pc_plus_1", id_pc_plus_1, 32'd0);
      checkOutput("rst_pc_write", 32'(pc_write), 32'd0);
      checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
   endtask

   task automatic doReset(input int cycles);
      reset      = 1'b1;
      stall      = 1'b0;
      flush      = 1'b0;
      imem_ready = 1'b0;
      modelReset();
      repeat (cycles) @(posedge clk);
      #1;
      checkReset();
      reset = 1'b0;
   endtask

   // One clock cycle: drive inputs, check combinational handshake, advance model past the edge
   task automatic applyStimulus();
      logic        rdy;
      logic        load_now;
      logic        hold_busy;
      logic        deliver;
      logic        was_flush;
      logic        m_valid_nxt;
      logic        holding_nxt;
      logic [31:0] target;
      logic [31:0] pc_nxt;
      rdy = 1'b0;
      if (outstanding) begin
         lat_left--;
         rdy = (lat_left == 0);
      end
      imem_ready = rdy;
      imem_rdata = rdy ? mem_word(req_pc) : $urandom;
      stall      = ($urandom_range(99) < stall_pct);
      flush      = ($urandom_range(99) < flush_pct) && !(rdy && killed);
      pc_in      = pc_model;
      #1;
      hold_busy = stall && m_valid;
      load_now  = flush ? 1'b0 : (holding ? !stall : (rdy && !killed && !hold_busy));
      checkOutput("pc_write", 32'(pc_write), 32'(flush || load_now));
      checkOutput("imem_req", 32'(imem_req), 32'(!holding));
      if (!outstanding && imem_req) begin
         outstanding = 1;
         killed      = 0;
         req_pc      = pc_in;
         lat_left    = $urandom_range(lat_max, lat_min);
      end
      if (outstanding) checkOutput("imem_addr", imem_addr, req_pc);
      if (outstanding && flush) killed = 1;
      deliver = rdy && !killed;
      if (deliver) sb_q.push_back('{req_pc, mem_word(req_pc)});
      if (holding && flush && sb_q.size() > 0) void'(sb_q.pop_back());
      if (hold_busy) stall_model++;
      if (load_now) loads_model++;
      m_valid_nxt = flush ? 1'b0 : (load_now ? 1'b1 : ((holding || hold_busy) ? m_valid : 1'b0));
      holding_nxt = flush ? 1'b0 : (holding ? stall : (deliver && hold_busy));
      if (rdy) outstanding = 0;
      case ($urandom_range(3))
         0:       target = 32'd5;
         1:       target = 32'hFFFF_FFFF;
         2:       target = 32'hFFFF_FFFE;
         default: target = $urandom;
      endcase
      pc_nxt    = flush ? target : (pc_write ? pc_model + 32'd1 : pc_model);
      was_flush = flush;
      @(posedge clk);
      #1;
      m_valid  = m_valid_nxt;
      holding  = holding_nxt;
      pc_model = pc_nxt;
      checkOutput("id_valid", 32'(id_valid), 32'(m_valid));
      if (was_flush) checkOutput("flush_nop", id_instr, 32'(NOP_INSTR));
   endtask

   // Monitor: every fresh IF/ID load must match the oldest expected fetch
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         mon_valid = 0;
      end else begin
         if (id_valid && (!mon_valid || id_pc != mon_pc || id_instr != mon_instr)) begin
            loads_seen++;
            if (sb_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL sb_unexpected: got load pc 0x%08h, expected none at %0t", id_pc, $time);
            end else begin
               e = sb_q.pop_front();
               checkOutput("sb_id_pc", id_pc, e.pc);
               checkOutput("sb_id_instr", id_instr, e.instr);
               checkOutput("sb_id_pc_plus_1", id_pc_plus_1, e.pc + 32'd1);
            end
         end
         mon_valid = id_valid;
         mon_pc    = id_pc;
         mon_instr = id_instr;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset      = 1'b1;
      stall      = 1'b0;
      flush      = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = '0;
      pc_in      = '0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkReset();
      reset = 1'b0;

      $display("[TB] single-cycle memory, no stalls");
      lat_min = 1; lat_max = 1;
      repeat (12) applyStimulus();

      $display("[TB] three-cycle memory");
      lat_min = 3; lat_max = 3;
      repeat (20) applyStimulus();

      $display("[TB] random latency with stalls");
      lat_min = 1; lat_max = 3; stall_pct = 40;
      repeat (80) applyStimulus();

      $display("[TB] random stalls and flushes");
      flush_pct = 15;
      repeat (400) applyStimulus();

      $display("[TB] reset during an outstanding request");
      n = 0;
      while (!outstanding && n < 10) begin
         applyStimulus();
         n++;
      end
      doReset(2);
      repeat (200) applyStimulus();

      stall_pct = 0;
      flush_pct = 0;
      n = 0;
      while ((outstanding || holding) && n < 50) begin
         applyStimulus();
         n++;
      end
      if (outstanding || holding) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain_timeout: got busy after %0d cycles, expected idle", n);
      end
      @(negedge clk);
      #1;
      checkOutput("sb_leftover", 32'(sb_q.size()), 32'd0);
      checkOutput("load_count", 32'(loads_seen), 32'(loads_model));
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perf_fetched", perf_fetched, 32'(loads_model));
      checkOutput("perf_stall_cycles", perf_stall_cycles, 32'(stall_model));
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
